// File: rtl/apb_master_pkg.sv
// Shared types for the APB master bridge: FSM states, buffered request layout
// and bus widths.
package apb_master_pkg;

   localparam int APB_DATA_WIDTH     = 32;
   localparam int APB_MAX_ADDR_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_t;

   // Address is stored at full width so one entry layout serves any window size
   typedef struct packed {
      logic                          we;
      logic [APB_MAX_ADDR_WIDTH-1:0] addr;
      logic [APB_DATA_WIDTH-1:0]     wdata;
   } apb_req_t;

endpackage

// File: rtl/apb_req_fifo.sv
// In-order request buffer between the core-side handshake and the APB FSM.
// Pointers carry an extra wrap bit so full and empty are told apart without a counter.
module apb_req_fifo
   import apb_master_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic     clock,
   input  logic     reset,
   input  logic     push,
   input  apb_req_t push_data,
   output logic     full,
   input  logic     pop,
   output apb_req_t pop_data,
   output logic     empty
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   apb_req_t         mem [FIFO_DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign pop_data = mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clock) begin
      if (push && !full) begin
         mem[wr_ptr[PTR_W-1:0]] <= push_data;
      end
   end

   // Reset flushes by realigning the pointers; stale entries are never read
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + (PTR_W+1)'(1);
         end
      end
   end

endmodule

// File: rtl/apb_master_bridge.sv
// Core req/gnt/rvalid to APB3 initiator with an in-order request FIFO.
// Optional ACCESS wait-state timeout is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_bridge
   import apb_master_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int FIFO_DEPTH     = 2,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      HCLK,
   input  logic                      HRESET,
   input  logic                      req_i,
   input  logic                      we_i,
   input  logic [APB_ADDR_WIDTH-1:0] addr_i,
   input  logic [APB_DATA_WIDTH-1:0] wdata_i,
   output logic                      gnt_o,
   output logic                      rvalid_o,
   output logic [APB_DATA_WIDTH-1:0] rdata_o,
   output logic                      err_o,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [APB_DATA_WIDTH-1:0] PWDATA,
   output logic                      PWRITE,
   output logic                      PSEL,
   output logic                      PENABLE,
   input  logic [APB_DATA_WIDTH-1:0] PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   apb_state_t                    state_q;
   apb_state_t                    state_d;
   apb_req_t                      push_req;
   apb_req_t                      pop_req;
   logic                          fifo_full;
   logic                          fifo_empty;
   logic                          fifo_pop;
   logic                          respond;
   logic                          timeout_hit;
   logic [APB_MAX_ADDR_WIDTH-1:0] unused_addr;

   assign gnt_o       = !fifo_full && !HRESET;
   assign push_req    = '{we: we_i, addr: APB_MAX_ADDR_WIDTH'(addr_i), wdata: wdata_i};
   assign unused_addr = pop_req.addr;
   assign PSEL        = (state_q != IDLE);
   assign PENABLE     = (state_q == ACCESS);

   apb_req_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_req_fifo (
      .clock     (HCLK),
      .reset     (HRESET),
      .push      (req_i && gnt_o),
      .push_data (push_req),
      .full      (fifo_full),
      .pop       (fifo_pop),
      .pop_data  (pop_req),
      .empty     (fifo_empty)
   );

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt;

   // Limit is hit on the ACCESS cycle that would bring the count to TIMEOUT_CYCLES
   assign timeout_hit = (state_q == ACCESS) && !PREADY &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge HCLK) begin
      if (HRESET || (state_q != ACCESS)) begin
         wait_cnt <= '0;
      end else if (!PREADY) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

   assign timeout_hit = 1'b0;
`endif

   // Completion and the next pop share a cycle so PSEL stays high back-to-back
   always_comb begin
      state_d  = state_q;
      fifo_pop = 1'b0;
      respond  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (PREADY || timeout_hit) begin
               respond = 1'b1;
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  state_d  = SETUP;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q  <= IDLE;
         PADDR    <= '0;
         PWDATA   <= '0;
         PWRITE   <= 1'b0;
         rvalid_o <= 1'b0;
         rdata_o  <= '0;
         err_o    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rvalid_o <= respond;
         if (fifo_pop) begin
            PADDR  <= pop_req.addr[APB_ADDR_WIDTH-1:0];
            PWDATA <= pop_req.wdata;
            PWRITE <= pop_req.we;
         end
         // Slave signals are only trusted when PREADY is high; a timeout is an error
         if (respond) begin
            err_o   <= PREADY ? PSLVERR : 1'b1;
            rdata_o <= (PREADY && !PWRITE && !PSLVERR) ? PRDATA : '0;
         end
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge; the timeout scenario runs
// only when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        req_i;
   logic        we_i;
   logic [11:0] addr_i;
   logic [31:0] wdata_i;
   logic        gnt_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic [11:0] PADDR;
   logic [31:0] PWDATA;
   logic        PWRITE;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   int checks   = 0;
   int failures = 0;

   always #5 HCLK = ~HCLK;

   apb_master_bridge #(
      .APB_ADDR_WIDTH (12),
      .FIFO_DEPTH     (2),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .HCLK     (HCLK),
      .HRESET   (HRESET),
      .req_i    (req_i),
      .we_i     (we_i),
      .addr_i   (addr_i),
      .wdata_i  (wdata_i),
      .gnt_o    (gnt_o),
      .rvalid_o (rvalid_o),
      .rdata_o  (rdata_o),
      .err_o    (err_o),
      .PADDR    (PADDR),
      .PWDATA   (PWDATA),
      .PWRITE   (PWRITE),
      .PSEL     (PSEL),
      .PENABLE  (PENABLE),
      .PRDATA   (PRDATA),
      .PREADY   (PREADY),
      .PSLVERR  (PSLVERR)
   );

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic test_reset();
      HRESET = 1'b1;
      req_i  = 1'b1;
      tick();
      tick();
      checks++;
      if ({PSEL, PENABLE, rvalid_o, err_o, PWRITE} !== 5'b00000) begin
         failures++;
         $display("[TB] FAIL reset_ctrl: PSEL/PENABLE/rvalid/err/PWRITE=%b expected 00000",
                  {PSEL, PENABLE, rvalid_o, err_o, PWRITE});
      end
      checks++;
      if ({PADDR, PWDATA, rdata_o} !== 76'd0) begin
         failures++;
         $display("[TB] FAIL reset_data: PADDR=%h PWDATA=%h rdata=%h expected all zero",
                  PADDR, PWDATA, rdata_o);
      end
      checks++;
      if (gnt_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_gnt: gnt_o=%b expected 0", gnt_o);
      end
      req_i  = 1'b0;
      HRESET = 1'b0;
      #1;
      checks++;
      if (gnt_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL post_reset_gnt: gnt_o=%b expected 1", gnt_o);
      end
      tick();
   endtask

   task automatic test_single_read();
      PREADY = 1'b1;
      PRDATA = 32'hDEADBEEF;
      req_i  = 1'b1;
      we_i   = 1'b0;
      addr_i = 12'h004;
      #1;
      checks++;
      if (gnt_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL read_gnt: gnt_o=%b expected 1", gnt_o);
      end
      tick();
      req_i = 1'b0;
      checks++;
      if (PSEL !== 1'b0) begin
         failures++;
         $display("[TB] FAIL read_idle: PSEL=%b expected 0", PSEL);
      end
      tick();
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR} !== {3'b100, 12'h004}) begin
         failures++;
         $display("[TB] FAIL read_setup: PSEL/PENABLE/PWRITE=%b PADDR=%h expected 100 004",
                  {PSEL, PENABLE, PWRITE}, PADDR);
      end
      tick();
      checks++;
      if ({PSEL, PENABLE, rvalid_o} !== 3'b110) begin
         failures++;
         $display("[TB] FAIL read_access: PSEL/PENABLE/rvalid=%b expected 110",
                  {PSEL, PENABLE, rvalid_o});
      end
      tick();
      checks++;
      if ({rvalid_o, err_o, rdata_o} !== {2'b10, 32'hDEADBEEF}) begin
         failures++;
         $display("[TB] FAIL read_resp: rvalid/err=%b rdata=%h expected 10 deadbeef",
                  {rvalid_o, err_o}, rdata_o);
      end
      checks++;
      if ({PSEL, PENABLE} !== 2'b00) begin
         failures++;
         $display("[TB] FAIL read_end: PSEL/PENABLE=%b expected 00", {PSEL, PENABLE});
      end
      tick();
      checks++;
      if (rvalid_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL read_pulse: rvalid_o=%b expected 0", rvalid_o);
      end
   endtask

   task automatic test_write_wait();
      PREADY  = 1'b0;
      PRDATA  = 32'hCAFEF00D;
      req_i   = 1'b1;
      we_i    = 1'b1;
      addr_i  = 12'h100;
      wdata_i = 32'h1;
      tick();
      req_i = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if ({PSEL, PENABLE, rvalid_o} !== 3'b110) begin
         failures++;
         $display("[TB] FAIL write_wait1: PSEL/PENABLE/rvalid=%b expected 110",
                  {PSEL, PENABLE, rvalid_o});
      end
      tick();
      checks++;
      if ({PADDR, PWDATA, PWRITE, rvalid_o} !== {12'h100, 32'h1, 2'b10}) begin
         failures++;
         $display("[TB] FAIL write_hold: PADDR=%h PWDATA=%h PWRITE/rvalid=%b expected 100 1 10",
                  PADDR, PWDATA, {PWRITE, rvalid_o});
      end
      PREADY = 1'b1;
      tick();
      checks++;
      if ({rvalid_o, err_o, rdata_o} !== {2'b10, 32'h0}) begin
         failures++;
         $display("[TB] FAIL write_resp: rvalid/err=%b rdata=%h expected 10 0",
                  {rvalid_o, err_o}, rdata_o);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_data [4];
      exp_data[0] = 32'hA;
      exp_data[1] = 32'hB;
      exp_data[2] = 32'hC;
      exp_data[3] = 32'hD;
      PREADY = 1'b0;
      we_i   = 1'b0;
      req_i  = 1'b1;
      addr_i = 12'h010;
      tick();
      addr_i = 12'h020;
      tick();
      addr_i = 12'h030;
      tick();
      addr_i = 12'h040;
      #1;
      checks++;
      if (gnt_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL b2b_full: gnt_o=%b expected 0", gnt_o);
      end
      tick();
      checks++;
      if ({gnt_o, PENABLE, PADDR} !== {2'b01, 12'h010}) begin
         failures++;
         $display("[TB] FAIL b2b_stall: gnt/PENABLE=%b PADDR=%h expected 01 010",
                  {gnt_o, PENABLE}, PADDR);
      end
      PREADY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         PRDATA = exp_data[i];
         tick();
         checks++;
         if ({rvalid_o, rdata_o} !== {1'b1, exp_data[i]}) begin
            failures++;
            $display("[TB] FAIL b2b_resp%0d: rvalid=%b rdata=%h expected 1 %h",
                     i, rvalid_o, rdata_o, exp_data[i]);
         end
         checks++;
         if (i < 3 && ({PSEL, PENABLE, PADDR} !== {2'b10, 12'h020 + 12'(i * 16)})) begin
            failures++;
            $display("[TB] FAIL b2b_next%0d: PSEL/PENABLE=%b PADDR=%h expected 10 %h",
                     i, {PSEL, PENABLE}, PADDR, 12'h020 + 12'(i * 16));
         end else if (i == 3 && PSEL !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_idle: PSEL=%b expected 0", PSEL);
         end
         if (i == 0) begin
            checks++;
            if (gnt_o !== 1'b1) begin
               failures++;
               $display("[TB] FAIL b2b_regnt: gnt_o=%b expected 1", gnt_o);
            end
         end
         if (i == 0) begin
            tick();
            req_i = 1'b0;
         end else if (i < 3) begin
            tick();
         end
      end
      tick();
   endtask

   task automatic test_slave_error();
      PREADY  = 1'b1;
      PSLVERR = 1'b1;
      PRDATA  = 32'h55AA55AA;
      req_i   = 1'b1;
      we_i    = 1'b0;
      addr_i  = 12'h008;
      tick();
      req_i = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if ({rvalid_o, err_o} !== 2'b11) begin
         failures++;
         $display("[TB] FAIL slverr_resp: rvalid/err=%b expected 11", {rvalid_o, err_o});
      end
      PSLVERR = 1'b0;
      PRDATA  = 32'h12345678;
      req_i   = 1'b1;
      addr_i  = 12'h00C;
      tick();
      req_i = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if ({rvalid_o, err_o, rdata_o} !== {2'b10, 32'h12345678}) begin
         failures++;
         $display("[TB] FAIL slverr_next: rvalid/err=%b rdata=%h expected 10 12345678",
                  {rvalid_o, err_o}, rdata_o);
      end
      tick();
   endtask

   task automatic test_reset_mid_access();
      PREADY = 1'b0;
      we_i   = 1'b0;
      req_i  = 1'b1;
      addr_i = 12'h200;
      tick();
      addr_i = 12'h204;
      tick();
      req_i = 1'b0;
      tick();
      HRESET = 1'b1;
      tick();
      checks++;
      if ({PSEL, PENABLE, rvalid_o} !== 3'b000) begin
         failures++;
         $display("[TB] FAIL rst_mid_bus: PSEL/PENABLE/rvalid=%b expected 000",
                  {PSEL, PENABLE, rvalid_o});
      end
      HRESET = 1'b0;
      PREADY = 1'b1;
      #1;
      checks++;
      if (gnt_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL rst_mid_gnt: gnt_o=%b expected 1", gnt_o);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({PSEL, rvalid_o} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL rst_mid_flush%0d: PSEL/rvalid=%b expected 00",
                     i, {PSEL, rvalid_o});
         end
      end
   endtask

`ifdef APB_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      PREADY = 1'b0;
      PRDATA = 32'hFFFFFFFF;
      req_i  = 1'b1;
      we_i   = 1'b0;
      addr_i = 12'h044;
      tick();
      req_i = 1'b0;
      tick();
      tick();
      tick();
      tick();
      tick();
      checks++;
      if ({PSEL, PENABLE, rvalid_o} !== 3'b110) begin
         failures++;
         $display("[TB] FAIL timeout_wait: PSEL/PENABLE/rvalid=%b expected 110",
                  {PSEL, PENABLE, rvalid_o});
      end
      tick();
      checks++;
      if ({rvalid_o, err_o, rdata_o, PSEL, PENABLE} !== {2'b11, 32'h0, 2'b00}) begin
         failures++;
         $display("[TB] FAIL timeout_abort: rvalid/err=%b rdata=%h PSEL/PENABLE=%b expected 11 0 00",
                  {rvalid_o, err_o}, rdata_o, {PSEL, PENABLE});
      end
      PREADY = 1'b1;
      tick();
   endtask
`endif

   initial begin
      HRESET  = 1'b1;
      req_i   = 1'b0;
      we_i    = 1'b0;
      addr_i  = '0;
      wdata_i = '0;
      PRDATA  = '0;
      PREADY  = 1'b1;
      PSLVERR = 1'b0;
      test_reset();
      test_single_read();
      test_write_wait();
      test_back_to_back();
      test_slave_error();
      test_reset_mid_access();
`ifdef APB_MASTER_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
